// File: rtl/sipo_demux8_if.sv
// Serial-in / parallel-out bundle for sipo_demux8; the slave modport is the demux side.
// SIPO_DEMUX8_PARITY_EN adds y_par_err and widens sel by one bit.
interface sipo_demux8_if #(
  parameter int SEL_W = 3
);
  localparam int N = 2**SEL_W;
`ifdef SIPO_DEMUX8_PARITY_EN
  localparam int CNT_W = SEL_W + 1;
`else
  localparam int CNT_W = SEL_W;
`endif

  logic             din;
  logic             din_valid;
  logic             din_ready;
  logic             sel_clr;
  logic [CNT_W-1:0] sel;
  logic [N-1:0]     Y;
  logic             y_valid;
  logic             y_ready;
`ifdef SIPO_DEMUX8_PARITY_EN
  logic             y_par_err;
`endif

  modport master (
    output din, din_valid, sel_clr, y_ready,
`ifdef SIPO_DEMUX8_PARITY_EN
    input  y_par_err,
`endif
    input  din_ready, sel, Y, y_valid
  );

  modport slave (
    input  din, din_valid, sel_clr, y_ready,
`ifdef SIPO_DEMUX8_PARITY_EN
    output y_par_err,
`endif
    output din_ready, sel, Y, y_valid
  );
endinterface

// File: rtl/sipo_demux8.sv
// Serial-to-parallel 1-to-8 demux: steers accepted bits into a staging word, then hands
// the word out through a registered valid/ready port. SIPO_DEMUX8_PARITY_EN appends an even-parity bit.
module sipo_demux8 #(
  parameter bit MSB_FIRST = 1'b0,
  parameter int SEL_W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  sipo_demux8_if.slave bus
);
  localparam int N = 2**SEL_W;
`ifdef SIPO_DEMUX8_PARITY_EN
  localparam int CNT_W = SEL_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N);
`else
  localparam int CNT_W = SEL_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
`endif

  logic [CNT_W-1:0] sel_p0;
  logic [N-1:0]     stg_p0;
  logic [N-1:0]     y_p1;
  logic             vld_p1;
`ifdef SIPO_DEMUX8_PARITY_EN
  logic             par_err_p1;
`endif

  logic             last;
  logic             ready;
  logic             acc;
  logic [SEL_W-1:0] idx;
  logic [N-1:0]     stg_ins;
  logic [N-1:0]     word_c;

  always_comb begin
    last    = (sel_p0 == LAST);
    ready   = !(last && vld_p1 && !bus.y_ready);
    acc     = bus.din_valid && ready;
    idx     = MSB_FIRST ? ~sel_p0[SEL_W-1:0] : sel_p0[SEL_W-1:0];
    stg_ins = stg_p0;
    stg_ins[idx] = bus.din;
`ifdef SIPO_DEMUX8_PARITY_EN
    // The completing bit is the parity bit, so the data bits are already in place.
    word_c  = stg_p0;
`else
    word_c  = stg_ins;
`endif
  end

  // Stage p0 (staging word and index) -> stage p1 (output register)
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_p0     <= '0;
      stg_p0     <= '0;
      y_p1       <= '0;
      vld_p1     <= 1'b0;
`ifdef SIPO_DEMUX8_PARITY_EN
      par_err_p1 <= 1'b0;
`endif
    end else begin
      if (vld_p1 && bus.y_ready) begin
        vld_p1     <= 1'b0;
`ifdef SIPO_DEMUX8_PARITY_EN
        par_err_p1 <= 1'b0;
`endif
      end
      // A resync discards the offered bit, even when it would complete the word.
      if (bus.sel_clr) begin
        sel_p0 <= '0;
        stg_p0 <= '0;
      end else if (acc) begin
        if (last) begin
          y_p1       <= word_c;
          vld_p1     <= 1'b1;
          sel_p0     <= '0;
          stg_p0     <= '0;
`ifdef SIPO_DEMUX8_PARITY_EN
          par_err_p1 <= (^stg_p0) ^ bus.din;
`endif
        end else begin
          stg_p0 <= stg_ins;
          sel_p0 <= sel_p0 + 1'b1;
        end
      end
    end
  end

  assign bus.din_ready = ready;
  assign bus.sel       = sel_p0;
  assign bus.Y         = y_p1;
  assign bus.y_valid   = vld_p1;
`ifdef SIPO_DEMUX8_PARITY_EN
  assign bus.y_par_err = par_err_p1;
`endif
endmodule
